// File: rtl/i2c_codec_responder.sv
// I2C write-only target emulating the WM8731 control port.
// Oversamples SCL/SDA, ACKs 3-byte register writes addressed to DEV_ADDR,
// stores 9-bit values in a local register file and strobes every accepted write.
module i2c_codec_responder #(
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [6:0]  RESET_REG = 7'h0F
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_busy,
    output logic [7:0] o_wr_cnt
);

    localparam int unsigned AW         = $clog2(NUM_REGS);
    localparam logic [7:0]  NUM_REGS_W = 8'(NUM_REGS);

    typedef enum logic [2:0] {
        StIdle,
        StDev,
        StAckDev,
        StB1,
        StAck1,
        StB2,
        StAck2,
        StNackWait
    } state_e;

    state_e      state_q, state_d;
    logic        scl_s1, scl_s2, scl_h;
    logic        sda_s1, sda_s2, sda_h;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shreg_q, shreg_d;
    logic [7:0]  byte_in;
    logic        ack_on_q, ack_on_d;
    logic        busy_q, busy_d;
    logic [6:0]  reg_addr_q, reg_addr_d;
    logic [8:0]  data_q, data_d;
    logic        commit;
    logic        wr_valid_q;
    logic [6:0]  wr_addr_q;
    logic [8:0]  wr_data_q;
    logic [7:0]  wr_cnt_q;
    logic [8:0]  rd_data_q;
    logic [8:0]  regs [NUM_REGS];

    // Two-flop synchronizers plus one history stage for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_s1 <= 1'b0;
            scl_s2 <= 1'b0;
            scl_h  <= 1'b0;
            sda_s1 <= 1'b0;
            sda_s2 <= 1'b0;
            sda_h  <= 1'b0;
        end else begin
            scl_s1 <= i_scl;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= i_sda;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    assign scl_rise = scl_s2 & ~scl_h;
    assign scl_fall = ~scl_s2 & scl_h;
    // SCL must be high on both samples so an SDA change alongside an SCL edge
    // is never mistaken for START/STOP.
    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
    assign byte_in   = {shreg_q, sda_s2};

    // Next-state logic: bus conditions first, then per-state bit/ACK handling.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ack_on_d   = ack_on_q;
        busy_d     = busy_q;
        reg_addr_d = reg_addr_q;
        data_d     = data_q;
        commit     = 1'b0;
        if (start_det) begin
            state_d   = StDev;
            bit_cnt_d = 4'd0;
            ack_on_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = 4'd0;
            ack_on_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                StDev, StB1, StB2: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (state_q == StDev) begin
                                if (byte_in[7:1] == DEV_ADDR && !byte_in[0]) begin
                                    state_d = StAckDev;
                                end else begin
                                    state_d = StIdle;
                                end
                            end else if (state_q == StB1) begin
                                reg_addr_d = byte_in[7:1];
                                data_d[8]  = byte_in[0];
                                state_d    = StAck1;
                            end else begin
                                data_d[7:0] = byte_in;
                                state_d     = StAck2;
                            end
                        end
                    end
                end
                StAckDev, StAck1, StAck2: begin
                    // First fall drives ACK, second fall (end of 9th clock) releases.
                    if (scl_fall) begin
                        if (!ack_on_q) begin
                            ack_on_d = 1'b1;
                        end else begin
                            ack_on_d = 1'b0;
                            case (state_q)
                                StAckDev: state_d = StB1;
                                StAck1:   state_d = StB2;
                                default: begin
                                    state_d = StNackWait;
                                    commit  = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM and transaction state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= 7'd0;
            ack_on_q   <= 1'b0;
            busy_q     <= 1'b0;
            reg_addr_q <= 7'd0;
            data_q     <= 9'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ack_on_q   <= ack_on_d;
            busy_q     <= busy_d;
            reg_addr_q <= reg_addr_d;
            data_q     <= data_d;
        end
    end

    // Commit strobe, last-write capture and wrapping write counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 7'd0;
            wr_data_q  <= 9'd0;
            wr_cnt_q   <= 8'd0;
        end else begin
            wr_valid_q <= commit;
            if (commit) begin
                wr_addr_q <= reg_addr_q;
                wr_data_q <= data_q;
                wr_cnt_q  <= wr_cnt_q + 8'd1;
            end
        end
    end

    // Register file: RESET_REG clears everything, out-of-range addresses are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'd0;
        end else if (commit) begin
            if (reg_addr_q == RESET_REG) begin
                for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'd0;
            end else if ({1'b0, reg_addr_q} < NUM_REGS_W) begin
                regs[reg_addr_q[AW-1:0]] <= data_q;
            end
        end
    end

    // Registered readback port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_data_q <= 9'd0;
        end else begin
            rd_data_q <= regs[i_rd_addr];
        end
    end

    assign o_sda_oe   = ack_on_q;
    assign o_busy     = busy_q;
    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_wr_cnt   = wr_cnt_q;
    assign o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: a bit-banged I2C master drives the
// bus (open-drain SDA modelled as wired-AND) and each scenario checks its results.
module tb_i2c_codec_responder;

    localparam int Q = 5;  // quarter SCL period in system clocks

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_m;
    logic [3:0] rd_addr;
    wire        sda_bus;
    logic       o_sda_oe, o_wr_valid, o_busy;
    logic [6:0] o_wr_addr;
    logic [8:0] o_wr_data, o_rd_data;
    logic [7:0] o_wr_cnt;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    int oe_cycles = 0;

    assign sda_bus = sda_m & ~o_sda_oe;

    i2c_codec_responder dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_scl      (scl),
        .i_sda      (sda_bus),
        .o_sda_oe   (o_sda_oe),
        .o_wr_valid (o_wr_valid),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (o_rd_data),
        .o_busy     (o_busy),
        .o_wr_cnt   (o_wr_cnt)
    );

    always #5 clk = ~clk;

    // Count strobe cycles and ACK-drive cycles on the inactive edge.
    always @(negedge clk) begin
        if (o_wr_valid === 1'b1) wr_pulses++;
        if (o_sda_oe === 1'b1) oe_cycles++;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dut_reset();
        scl = 1'b1;
        sda_m = 1'b1;
        rd_addr = 4'd0;
        rst = 1'b1;
        wait_n(3);
        rst = 1'b0;
        wait_n(4 * Q);
    endtask

    // START or repeated START; leaves SCL low.
    task automatic i2c_start();
        sda_m = 1'b1;
        wait_n(Q);
        scl = 1'b1;
        wait_n(Q);
        sda_m = 1'b0;
        wait_n(Q);
        scl = 1'b0;
        wait_n(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_n(Q);
        scl = 1'b1;
        wait_n(Q);
        sda_m = 1'b1;
        wait_n(2 * Q);
    endtask

    // Sends the top nbits of b MSB first; with nbits==8 also clocks the ACK slot.
    task automatic send_byte(input logic [7:0] b, input int nbits, output logic ack);
        for (int i = 7; i >= 8 - nbits; i--) begin
            sda_m = b[i];
            wait_n(Q);
            scl = 1'b1;
            wait_n(2 * Q);
            scl = 1'b0;
            wait_n(Q);
        end
        ack = 1'b0;
        if (nbits == 8) begin
            sda_m = 1'b1;
            wait_n(Q);
            scl = 1'b1;
            wait_n(Q);
            ack = (o_sda_oe === 1'b1) && (sda_bus === 1'b0);
            wait_n(Q);
            scl = 1'b0;
            wait_n(Q);
        end
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [8:0] v);
        rd_addr = a;
        wait_n(1);
        v = o_rd_data;
    endtask

    task automatic test_reset();
        dut_reset();
        checks++;
        if ({o_sda_oe, o_wr_valid, o_busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {o_sda_oe, o_wr_valid, o_busy});
        end
        checks++;
        if ({o_wr_addr, o_wr_data, o_rd_data, o_wr_cnt} !== 33'd0) begin
            errors++;
            $display("FAIL reset_values: got addr=%0h data=%0h rd=%0h cnt=%0d expected all 0",
                     o_wr_addr, o_wr_data, o_rd_data, o_wr_cnt);
        end
    endtask

    task automatic test_basic_write();
        logic [2:0] acks;
        logic [8:0] v;
        int p0, oe0;
        dut_reset();
        p0 = wr_pulses;
        oe0 = oe_cycles;
        i2c_start();
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_start: got %b expected 1", o_busy);
        end
        send_byte(8'h34, 8, acks[2]);
        send_byte(8'h08, 8, acks[1]);
        send_byte(8'h15, 8, acks[0]);
        i2c_stop();
        checks++;
        if (acks !== 3'b111) begin
            errors++;
            $display("FAIL basic_acks: got %b expected 111", acks);
        end
        checks++;
        if (oe_cycles - oe0 < 54 || oe_cycles - oe0 > 66) begin
            errors++;
            $display("FAIL basic_oe_window: got %0d cycles expected about 60", oe_cycles - oe0);
        end
        checks++;
        if (wr_pulses - p0 !== 1) begin
            errors++;
            $display("FAIL basic_strobe: got %0d pulses expected 1", wr_pulses - p0);
        end
        checks++;
        if (o_wr_addr !== 7'h04 || o_wr_data !== 9'h015) begin
            errors++;
            $display("FAIL basic_wr: got addr=%0h data=%0h expected 04/015", o_wr_addr, o_wr_data);
        end
        checks++;
        if (o_wr_cnt !== 8'd1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_cnt_busy: got cnt=%0d busy=%b expected 1/0", o_wr_cnt, o_busy);
        end
        read_reg(4'd4, v);
        checks++;
        if (v !== 9'h015) begin
            errors++;
            $display("FAIL basic_readback: got %0h expected 015", v);
        end
    endtask

    task automatic test_wrong_addr();
        logic [2:0] acks;
        int p0, oe0;
        dut_reset();
        p0 = wr_pulses;
        oe0 = oe_cycles;
        i2c_start();
        send_byte(8'h36, 8, acks[2]);
        send_byte(8'h08, 8, acks[1]);
        send_byte(8'h15, 8, acks[0]);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL wrong_busy_before_stop: got %b expected 1", o_busy);
        end
        i2c_stop();
        checks++;
        if (acks !== 3'b000 || oe_cycles != oe0) begin
            errors++;
            $display("FAIL wrong_no_ack: got acks=%b oe_cycles=%0d expected 000/0",
                     acks, oe_cycles - oe0);
        end
        checks++;
        if (wr_pulses != p0 || o_wr_cnt !== 8'd0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL wrong_no_commit: got pulses=%0d cnt=%0d busy=%b expected 0/0/0",
                     wr_pulses - p0, o_wr_cnt, o_busy);
        end
    endtask

    task automatic test_reset_reg();
        logic a;
        logic [8:0] v;
        dut_reset();
        i2c_start();
        send_byte(8'h34, 8, a);
        send_byte(8'h05, 8, a);
        send_byte(8'h7F, 8, a);
        i2c_stop();
        i2c_start();
        send_byte(8'h34, 8, a);
        send_byte(8'h06, 8, a);
        send_byte(8'h79, 8, a);
        i2c_stop();
        read_reg(4'd2, v);
        checks++;
        if (v !== 9'h17F) begin
            errors++;
            $display("FAIL rreg_reg2: got %0h expected 17f", v);
        end
        read_reg(4'd3, v);
        checks++;
        if (v !== 9'h079) begin
            errors++;
            $display("FAIL rreg_reg3: got %0h expected 079", v);
        end
        i2c_start();
        send_byte(8'h34, 8, a);
        send_byte(8'h1E, 8, a);
        send_byte(8'h00, 8, a);
        i2c_stop();
        read_reg(4'd2, v);
        checks++;
        if (v !== 9'h000) begin
            errors++;
            $display("FAIL rreg_reg2_cleared: got %0h expected 000", v);
        end
        read_reg(4'd3, v);
        checks++;
        if (v !== 9'h000) begin
            errors++;
            $display("FAIL rreg_reg3_cleared: got %0h expected 000", v);
        end
        checks++;
        if (o_wr_cnt !== 8'd3 || o_wr_addr !== 7'h0F) begin
            errors++;
            $display("FAIL rreg_cnt: got cnt=%0d addr=%0h expected 3/0f", o_wr_cnt, o_wr_addr);
        end
    endtask

    task automatic test_repeated_start();
        logic a;
        logic [8:0] v;
        int p0;
        dut_reset();
        p0 = wr_pulses;
        i2c_start();
        send_byte(8'h34, 8, a);
        send_byte(8'h0C, 8, a);
        i2c_start();
        send_byte(8'h34, 8, a);
        send_byte(8'h0E, 8, a);
        send_byte(8'hAA, 8, a);
        i2c_stop();
        checks++;
        if (wr_pulses - p0 !== 1 || o_wr_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rstart_single: got pulses=%0d cnt=%0d expected 1/1",
                     wr_pulses - p0, o_wr_cnt);
        end
        checks++;
        if (o_wr_addr !== 7'h07 || o_wr_data !== 9'h0AA) begin
            errors++;
            $display("FAIL rstart_wr: got addr=%0h data=%0h expected 07/0aa", o_wr_addr, o_wr_data);
        end
        read_reg(4'd6, v);
        checks++;
        if (v !== 9'h000) begin
            errors++;
            $display("FAIL rstart_dropped_reg6: got %0h expected 000", v);
        end
        read_reg(4'd7, v);
        checks++;
        if (v !== 9'h0AA) begin
            errors++;
            $display("FAIL rstart_reg7: got %0h expected 0aa", v);
        end
    endtask

    task automatic test_extra_byte();
        logic [3:0] acks;
        int p0;
        dut_reset();
        p0 = wr_pulses;
        i2c_start();
        send_byte(8'h34, 8, acks[3]);
        send_byte(8'h08, 8, acks[2]);
        send_byte(8'h15, 8, acks[1]);
        send_byte(8'h55, 8, acks[0]);
        i2c_stop();
        checks++;
        if (acks !== 4'b1110) begin
            errors++;
            $display("FAIL extra_acks: got %b expected 1110", acks);
        end
        checks++;
        if (wr_pulses - p0 !== 1 || o_wr_cnt !== 8'd1) begin
            errors++;
            $display("FAIL extra_single: got pulses=%0d cnt=%0d expected 1/1",
                     wr_pulses - p0, o_wr_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic a;
        int p0;
        dut_reset();
        p0 = wr_pulses;
        i2c_start();
        send_byte(8'h34, 8, a);
        send_byte(8'h08, 8, a);
        send_byte(8'h15, 4, a);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_busy_before: got %b expected 1", o_busy);
        end
        rst = 1'b1;
        wait_n(1);
        checks++;
        if (o_sda_oe !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_release: got oe=%b busy=%b expected 0/0", o_sda_oe, o_busy);
        end
        rst = 1'b0;
        wait_n(4 * Q);
        checks++;
        if (wr_pulses != p0 || o_wr_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rmid_no_commit: got pulses=%0d cnt=%0d expected 0/0",
                     wr_pulses - p0, o_wr_cnt);
        end
        i2c_start();
        send_byte(8'h34, 8, a);
        send_byte(8'h08, 8, a);
        send_byte(8'h15, 8, a);
        i2c_stop();
        checks++;
        if (o_wr_cnt !== 8'd1 || o_wr_data !== 9'h015 || wr_pulses - p0 !== 1) begin
            errors++;
            $display("FAIL rmid_followup: got cnt=%0d data=%0h pulses=%0d expected 1/015/1",
                     o_wr_cnt, o_wr_data, wr_pulses - p0);
        end
    endtask

    initial begin
        rst = 1'b1;
        scl = 1'b1;
        sda_m = 1'b1;
        rd_addr = 4'd0;
        test_reset();
        test_basic_write();
        test_wrong_addr();
        test_reset_reg();
        test_repeated_start();
        test_extra_byte();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_codec_responder.md
Name: i2c_codec_responder

Overview:
- Synthesizable I2C target (slave) that emulates the WM8731 control port: it is the responder for the codec-init I2C master.
- Oversamples SCL/SDA on the system clock, ACKs 3-byte register writes addressed to the codec, and stores 9-bit register values in a local register file.
- Used in loopback benches and on-FPGA self-test to check that initialization sequences reach the codec intact. Also exposes a per-write strobe and readback.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address (write byte 0x34).
- NUM_REGS, 16, register file depth; register addresses 0..NUM_REGS-1 are stored.
- RESET_REG, 7'h0F, writing this address (any data) clears the register file.

Ports:
- i_clk  input  1  system clock; must be at least 8x the SCL frequency.
- i_rst  input  1  synchronous, active-high reset.
- i_scl  input  1  I2C clock from the bus (asynchronous).
- i_sda  input  1  I2C data as seen on the bus (asynchronous).
- o_sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
- o_wr_valid  output  1  one-cycle strobe per accepted write.
- o_wr_addr  output  7  register address of the last accepted write.
- o_wr_data  output  9  data of the last accepted write.
- i_rd_addr  input  4  register file readback address.
- o_rd_data  output  9  registered readback; 1-cycle latency.
- o_busy  output  1  high from START until STOP or abort.
- o_wr_cnt  output  8  count of accepted writes; wraps 255 -> 0.

Behaviour:
- Reset (synchronous, i_rst=1 at a rising i_clk edge) forces:
  - o_sda_oe=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_rd_data=0, o_busy=0, o_wr_cnt=0;
  - all registers 0; FSM in IDLE.
  - Reset mid-transaction abandons the transaction with no write and releases SDA immediately.
- Input conditioning:
  - 2-FF synchronizer on i_scl and i_sda, plus one history stage for edge detection.
  - Bus events are seen 2-3 cycles late.
- Bus events:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Data bits are sampled on the synced SCL rising edge, MSB first.
- FSM states: IDLE, DEV, ACK_DEV, B1, ACK1, B2, ACK2, NACK_WAIT.
- START (from any state, including a repeated START) -> DEV: bit counter cleared, o_busy=1.
- STOP (from any state) -> IDLE: o_sda_oe=0, o_busy=0, no write unless ACK2 already completed.
- DEV, after the 8th bit:
  - Match condition: byte[7:1]==DEV_ADDR and byte[0]==0.
  - On match, go to ACK_DEV.
  - On no match, go to IDLE: no ACK, SDA stays released, the rest of the transaction is ignored until the next START.
- ACK states:
  - Assert o_sda_oe on the first synced SCL falling edge after the 8th bit.
  - Deassert on the next synced SCL falling edge (end of the 9th clock), then enter the next state.
  - ACK_DEV -> B1, ACK1 -> B2, ACK2 -> NACK_WAIT.
- B1 byte = {reg_addr[6:0], data[8]}. B2 byte = data[7:0].
- Write commit: in the cycle ACK2 releases SDA:
  - o_wr_valid=1 for exactly one cycle;
  - o_wr_addr/o_wr_data are updated and held until the next commit;
  - o_wr_cnt increments.
- Register file:
  - If reg_addr==RESET_REG, all registers clear to 0 (data ignored).
  - Else if reg_addr<NUM_REGS, the register is written.
  - Else nothing is stored, but the write is still ACKed and strobed.
- NACK_WAIT: any further bytes are not ACKed (SDA released); wait for STOP or repeated START.
- Readback: o_rd_data <= reg[i_rd_addr] every cycle. A same-cycle commit to that address is visible one cycle later.
- Glitch rule: SDA changes while SCL is low are data, never START/STOP. A bit sampled on SCL rise is the value after synchronization.

Test Plan:
- Bytes 0x34, 0x08, 0x15, then STOP -> three ACKs (o_sda_oe=1 during each 9th clock); one o_wr_valid pulse with o_wr_addr=0x04, o_wr_data=0x015; o_wr_cnt=1; i_rd_addr=4 gives o_rd_data=0x015 one cycle later.
- Bytes 0x36 (wrong address), 0x08, 0x15 -> o_sda_oe never asserts; no strobe; o_wr_cnt unchanged; o_busy falls at STOP.
- Sequence: write reg 2 = 0x17F (bytes 0x34, 0x05, 0x7F); write reg 3 = 0x079; then bytes 0x34, 0x1E, 0x00 (RESET_REG) -> reads of regs 2 and 3 return 0; o_wr_cnt=3.
- Bytes 0x34, 0x0C, then repeated START, then 0x34, 0x0E, 0xAA, STOP -> first transaction dropped; single commit with addr 0x07, data 0x0AA.
- A 4th byte 0x55 before STOP -> no ACK on the 4th byte; exactly one commit.
- Assert i_rst during B2 -> o_sda_oe=0 and o_busy=0 on the next cycle; no commit. A following full write succeeds with o_wr_cnt=1.
